// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bit_full_adder.sv
// One-bit full-adder cell reused by the serial adder datapath.
module bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: feeds one full-adder cell LSB first, one bit per clock.
// state  | meaning
// S_IDLE | waiting for start; operands captured on the accepting edge
// S_RUN  | one operand bit per edge through the full-adder cell
// S_DONE | result newly valid, done pulse; returns to idle next edge
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] psum;
    logic [WIDTH-1:0] psum_nx;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s, fa_c;
    logic             last_bit;

    bit_full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    // New bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
    assign psum_nx  = {fa_s, psum};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_RUN) || (state_q == S_DONE);
    assign done = (state_q == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        psum  <= '0;
                        cnt   <= '0;
                        carry <= 1'b0;
                    end
                end
                S_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_c;
                    psum  <= psum_nx[WIDTH-1:1];
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        sum  <= psum_nx;
                        cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
